// File: rtl/fp_pipe_stage.sv
// Elastic valid/ready pipeline register (DEPTH slices) for the FP adder datapath.
// Define FP_PIPE_SKID_EN to add a registered-ready skid slot ahead of slice 0.
module fp_pipe_stage #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(DEPTH+2)-1:0]    count
);

  localparam int CW = $clog2(DEPTH+2);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] adv;
  logic             accept;
  logic             deliver;
  logic             src_valid;
  logic [WIDTH-1:0] src_data;

`ifdef FP_PIPE_SKID_EN
  logic             s_valid_q, s_valid_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
`endif

  // A slice may load when it is empty or its occupant moves on this edge.
  always_comb begin : adv_chain
    logic run;
    adv = '0;
    run = !v_q[DEPTH-1] | out_ready;
    adv[DEPTH-1] = run;
    for (int k = DEPTH-2; k >= 0; k--) begin
      run = !v_q[k] | run;
      adv[k] = run;
    end
  end

  assign out_valid = v_q[DEPTH-1] & !flush;
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;
  assign deliver   = out_valid & out_ready;
  assign accept    = in_valid & in_ready;

`ifdef FP_PIPE_SKID_EN
  assign in_ready  = !s_valid_q & !flush;
  assign src_valid = s_valid_q | accept;
  assign src_data  = s_valid_q ? s_data_q : in_data;
`else
  assign in_ready  = adv[0] & !flush;
  assign src_valid = accept;
  assign src_data  = in_data;
`endif

  always_comb begin
    v_d = v_q;
    d_d = d_q;
`ifdef FP_PIPE_SKID_EN
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
`endif
    for (int k = 1; k < DEPTH; k++) begin
      if (adv[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) d_d[k] = d_q[k-1];
      end
    end
    if (adv[0]) begin
      v_d[0] = src_valid;
      if (src_valid) d_d[0] = src_data;
    end
`ifdef FP_PIPE_SKID_EN
    if (s_valid_q && adv[0]) begin
      s_valid_d = 1'b0;
    end else if (accept && !adv[0]) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
    end
`endif
    // Flush invalidates only; data registers keep their old contents.
    if (flush) begin
      v_d = '0;
`ifdef FP_PIPE_SKID_EN
      s_valid_d = 1'b0;
`endif
    end
  end

  always_comb begin
    count_d = count_q;
    if (accept && !deliver)      count_d = count_q + CW'(1);
    else if (deliver && !accept) count_d = count_q - CW'(1);
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
`ifdef FP_PIPE_SKID_EN
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
`endif
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= d_d[k];
`ifdef FP_PIPE_SKID_EN
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
`endif
    end
  end

endmodule
